// File: rtl/fifo_param_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// The status FSM encoding is fixed so that INIT is the all-zero reset value.
package fifo_param_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_NO_OP    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_READ     = 3'd3,
        ST_WR_RD    = 3'd4,
        ST_WR_ERR   = 3'd5,
        ST_RD_ERR   = 3'd6,
        ST_WR_RDERR = 3'd7
    } fifo_state_t;

    localparam int          ERRCNT_W   = 8;
    localparam logic [7:0]  ERRCNT_MAX = 8'hFF;

    // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// DATA_W x DEPTH storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module fifo_param_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with almost flags and a registered handshake status FSM.
// Optional saturating overflow/underflow counters are enabled by FIFO_PARAM_ERRCNT_EN.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CNT_W   = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err,
    output logic [CNT_W-1:0]  data_count,
    output logic [CNT_W-1:0]  next_data_count
`ifdef FIFO_PARAM_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] ovf_cnt,
    output logic [ERRCNT_W-1:0] unf_cnt
`endif
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    fifo_state_t       state_q, state_d;

    logic              rd_ok_s;
    logic              wr_ok_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_rdata_s;

    // Acceptance uses registered count; a read frees the slot a full-FIFO write needs.
    assign rd_ok_s  = rd_en && (count_q != {CNT_W{1'b0}});
    assign wr_ok_s  = wr_en && ((count_q != DEPTH_C) || rd_ok_s);
    assign mem_we_s = wr_ok_s && !reset;

    fifo_param_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (tail_q),
        .wdata (d_in),
        .raddr (head_q),
        .rdata (mem_rdata_s)
    );

    // Pointer, occupancy and read-data next-state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = {DATA_W{1'b0}};
        if (reset) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
            dout_d  = {DATA_W{1'b0}};
        end else begin
            count_d = count_q + CNT_W'(wr_ok_s) - CNT_W'(rd_ok_s);
            if (wr_ok_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (rd_ok_s) begin
                head_d = head_q + PTR_W'(1);
                dout_d = mem_rdata_s;
            end else begin
                head_d = head_q;
                dout_d = {DATA_W{1'b0}};
            end
        end
    end

    // Status FSM next-state: records what the coming edge does with the requests
    always_comb begin
        state_d = ST_NO_OP;
        if (reset) begin
            state_d = ST_INIT;
        end else if (wr_ok_s && rd_ok_s) begin
            state_d = ST_WR_RD;
        end else if (wr_ok_s && rd_en) begin
            state_d = ST_WR_RDERR;
        end else if (wr_ok_s) begin
            state_d = ST_WRITE;
        end else if (rd_ok_s) begin
            state_d = ST_READ;
        end else if (wr_en) begin
            state_d = ST_WR_ERR;
        end else if (rd_en) begin
            state_d = ST_RD_ERR;
        end else begin
            state_d = ST_NO_OP;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        dout_q  <= dout_d;
        state_q <= state_d;
    end

    // Handshake decode from the registered status
    always_comb begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
        case (state_q)
            ST_WRITE:    wr_ack = 1'b1;
            ST_READ:     rd_ack = 1'b1;
            ST_WR_RD: begin
                wr_ack = 1'b1;
                rd_ack = 1'b1;
            end
            ST_WR_ERR:   wr_err = 1'b1;
            ST_RD_ERR:   rd_err = 1'b1;
            ST_WR_RDERR: begin
                wr_ack = 1'b1;
                rd_err = 1'b1;
            end
            default: begin
                wr_ack = 1'b0;
                wr_err = 1'b0;
                rd_ack = 1'b0;
                rd_err = 1'b0;
            end
        endcase
    end

    assign d_out           = dout_q;
    assign data_count      = count_q;
    assign next_data_count = count_d;
    assign full            = (count_q == DEPTH_C);
    assign empty           = (count_q == {CNT_W{1'b0}});
    assign almost_full     = (count_q >= AF_C);
    assign almost_empty    = (count_q <= AE_C);

`ifdef FIFO_PARAM_ERRCNT_EN
    logic [ERRCNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [ERRCNT_W-1:0] unf_cnt_q, unf_cnt_d;

    // Saturating error counters keyed on the status the coming edge will record
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        unf_cnt_d = unf_cnt_q;
        if (reset) begin
            ovf_cnt_d = {ERRCNT_W{1'b0}};
            unf_cnt_d = {ERRCNT_W{1'b0}};
        end else begin
            if ((state_d == ST_WR_ERR) && (ovf_cnt_q != ERRCNT_MAX)) begin
                ovf_cnt_d = ovf_cnt_q + ERRCNT_W'(1);
            end else begin
                ovf_cnt_d = ovf_cnt_q;
            end
            if (((state_d == ST_RD_ERR) || (state_d == ST_WR_RDERR)) &&
                (unf_cnt_q != ERRCNT_MAX)) begin
                unf_cnt_d = unf_cnt_q + ERRCNT_W'(1);
            end else begin
                unf_cnt_d = unf_cnt_q;
            end
        end
    end

    // Error counter registers
    always_ff @(posedge clk) begin
        ovf_cnt_q <= ovf_cnt_d;
        unf_cnt_q <= unf_cnt_d;
    end

    assign ovf_cnt = ovf_cnt_q;
    assign unf_cnt = unf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed table, corner sequences and a random run
// against a queue-based reference model.
module tb_fifo_param;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic          full, empty, almost_full, almost_empty;
    logic          wr_ack, wr_err, rd_ack, rd_err;
    logic [CW-1:0] data_count;
    logic [CW-1:0] next_data_count;
`ifdef FIFO_PARAM_ERRCNT_EN
    logic [7:0]    ovf_cnt;
    logic [7:0]    unf_cnt;
`endif

    fifo_param #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .d_in            (d_in),
        .d_out           (d_out),
        .full            (full),
        .empty           (empty),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .wr_ack          (wr_ack),
        .wr_err          (wr_err),
        .rd_ack          (rd_ack),
        .rd_err          (rd_err),
        .data_count      (data_count),
        .next_data_count (next_data_count)
`ifdef FIFO_PARAM_ERRCNT_EN
        ,
        .ovf_cnt         (ovf_cnt),
        .unf_cnt         (unf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: FIFO contents as a queue plus last-edge handshake results
    logic [DW-1:0] mq [$];
    logic [DW-1:0] e_dout;
    logic          e_wa, e_we, e_ra, e_re;
    int            e_ovf, e_unf;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        logic [7:0]    flags;
        int            cnt;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] dut_flags();
        return {full, empty, almost_full, almost_empty, wr_ack, wr_err, rd_ack, rd_err};
    endfunction

    function automatic logic [7:0] model_flags();
        int n;
        n = mq.size();
        return {n == DEPTH, n == 0, n >= DEPTH - 2, n <= 2, e_wa, e_we, e_ra, e_re};
    endfunction

    // One clock with the given requests; model predicts, DUT is compared after the edge
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din);
        int n;
        bit rok, wok;
        wr_en = wr;
        rd_en = rd;
        d_in  = din;
        #1;
        n   = mq.size();
        rok = rd && (n > 0);
        wok = wr && ((n < DEPTH) || rok);
        chk("next_data_count", 32'(next_data_count), 32'(n + int'(wok) - int'(rok)));
        e_wa = wok;
        e_we = wr && !wok;
        e_ra = rok;
        e_re = rd && !rok;
        if (e_we && e_ovf < 255) e_ovf++;
        if (e_re && e_unf < 255) e_unf++;
        e_dout = '0;
        if (rok) e_dout = mq.pop_front();
        if (wok) mq.push_back(din);
        @(posedge clk);
        #1;
        chk("flags", 32'(dut_flags()), 32'(model_flags()));
        chk("data_count", 32'(data_count), 32'(mq.size()));
        chk("d_out", d_out, e_dout);
`ifdef FIFO_PARAM_ERRCNT_EN
        chk("ovf_cnt", 32'(ovf_cnt), 32'(e_ovf));
        chk("unf_cnt", 32'(unf_cnt), 32'(e_unf));
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset(input int ncyc, input logic wr);
        reset = 1'b1;
        wr_en = wr;
        rd_en = 1'b0;
        d_in  = 32'hDEAD_BEEF;
        repeat (ncyc) @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        mq.delete();
        e_wa = 1'b0; e_we = 1'b0; e_ra = 1'b0; e_re = 1'b0;
        e_ovf = 0;   e_unf = 0;
        // count 0: empty and almost_empty only, no handshakes
        chk("reset_flags", 32'(dut_flags()), 32'h50);
        chk("reset_count", 32'(data_count), 32'h0);
        chk("reset_d_out", d_out, 32'h0);
`ifdef FIFO_PARAM_ERRCNT_EN
        chk("reset_ovf", 32'(ovf_cnt), 32'h0);
        chk("reset_unf", 32'(unf_cnt), 32'h0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic [DW-1:0] r;
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; d_in = '0;
        e_ovf = 0; e_unf = 0;

        // Fill 1..8, overflow, drain 1..8, underflow
        for (int i = 0; i < 8; i++) begin
            k = i + 1;
            tbl[i] = '{1'b1, 1'b0, DW'(k),
                       {k == 8, 1'b0, k >= 6, k <= 2, 1'b1, 1'b0, 1'b0, 1'b0}, k, '0};
        end
        tbl[8] = '{1'b1, 1'b0, 32'd99, 8'b1010_0100, 8, '0};
        for (int i = 9; i < 17; i++) begin
            k = 16 - i;
            tbl[i] = '{1'b0, 1'b1, '0,
                       {1'b0, k == 0, k >= 6, k <= 2, 1'b0, 1'b0, 1'b1, 1'b0}, k, DW'(i - 8)};
        end
        tbl[17] = '{1'b0, 1'b1, '0, 8'b0101_0001, 0, '0};

        do_reset(2, 1'b0);
        step(1'b0, 1'b0, '0);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk("tbl_flags", 32'(dut_flags()), 32'(tbl[i].flags));
            chk("tbl_count", 32'(data_count), 32'(tbl[i].cnt));
            chk("tbl_d_out", d_out, tbl[i].dout);
        end

        // Full FIFO with both requests: both accepted, 0xA5 emerges on the 8th read
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(100 + i));
        step(1'b1, 1'b1, 32'hA5);
        chk("full_both_ack", 32'({wr_ack, rd_ack, data_count}), 32'h38);
        chk("full_both_dout", d_out, 32'd101);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        chk("a5_out", d_out, 32'hA5);

        // Empty FIFO with both requests: write accepted, read rejected, no bypass
        step(1'b1, 1'b1, 32'd77);
        chk("empty_both", 32'({wr_ack, rd_err, data_count}), 32'h31);
        chk("empty_both_dout", d_out, 32'h0);

        // Wrap-around at low occupancy
        step(1'b1, 1'b0, 32'd78);
        step(1'b1, 1'b0, 32'd79);
        for (int i = 0; i < 20; i++) begin
            r = $urandom;
            step(1'b1, 1'b0, r);
            step(1'b0, 1'b1, '0);
        end
        for (int i = 0; i < 20; i++) begin
            r = $urandom;
            step(1'b1, 1'b1, r);
        end

        // Random traffic: write-heavy phase then read-heavy phase
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if (i < 200) step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40, r);
            else         step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70, r);
        end

        // Reset mid-traffic at count 5 with a write pending
        do_reset(1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(200 + i));
        chk("pre_reset_count", 32'(data_count), 32'd5);
        do_reset(1, 1'b1);
        step(1'b0, 1'b1, '0);
        chk("post_reset_rd_err", 32'(rd_err), 32'h1);

`ifdef FIFO_PARAM_ERRCNT_EN
        do_reset(1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hBAD);
        chk("ovf_cnt_3", 32'(ovf_cnt), 32'd3);
        do_reset(1, 1'b0);
        chk("ovf_cnt_cleared", 32'(ovf_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
